// File: rtl/pipe_pkt_rx.sv
// pipe_pkt_rx: parses the host PipeIn word stream into {MAGIC,len} framed
// packets, buffers payload in a first-word-fall-through FIFO and presents it
// on a valid/ready stream with an end-of-packet marker.
// Ports:
//   okClk, rstn           clock, asynchronous active-low reset
//   pipe_in_data/valid    word stream from the PipeIn endpoint
//   blk_ready             registered block-throttle ready (>= BLOCK_WORDS free)
//   m_data/valid/last     FIFO head; m_ready accepts it
//   pkt_count, err_count  saturating packet / error counters
//   overflow              sticky, set by the first payload word dropped on full
module pipe_pkt_rx #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter logic [15:0] MAGIC       = 16'hA5A5
) (
    input  logic        okClk,
    input  logic        rstn,
    input  logic [31:0] pipe_in_data,
    input  logic        pipe_in_valid,
    output logic        blk_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [15:0] pkt_count,
    output logic [15:0] err_count,
    output logic        overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {
        HDR,
        PAYLOAD
    } state_t;

    state_t          state;
    logic [15:0]     remaining;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          mem [DEPTH];

    logic            full;
    logic            hdr_ok;
    logic            in_payload;
    logic            push;
    logic            pop;
    logic            err_evt;
    logic            pkt_evt;
    logic [CW-1:0]   count_next;
    entry_t          head;

    // Event decode; the full check sees the count before any same-cycle pop.
    always_comb begin
        full       = (count == CW'(DEPTH));
        hdr_ok     = (pipe_in_data[31:16] == MAGIC);
        in_payload = pipe_in_valid && (state == PAYLOAD);
        push       = in_payload && !full;
        pop        = m_valid && m_ready;
        err_evt    = (pipe_in_valid && (state == HDR) &&
                      (!hdr_ok || (pipe_in_data[15:0] == 16'd0))) ||
                     (in_payload && full);
        pkt_evt    = push && (remaining == 16'd1);
        count_next = count + CW'(push) - CW'(pop);
        head       = mem[rd_ptr];
    end

    // Head outputs are forced to zero while the FIFO is empty (covers reset).
    assign m_valid = (count != '0);
    assign m_data  = m_valid ? head.data : 32'd0;
    assign m_last  = m_valid && head.last;

    // FIFO storage; payload only, no reset needed.
    always_ff @(posedge okClk) begin
        if (push) begin
            mem[wr_ptr] <= '{last: (remaining == 16'd1), data: pipe_in_data};
        end
    end

    // Framing FSM, FIFO pointers and counters.
    always_ff @(posedge okClk or negedge rstn) begin
        if (!rstn) begin
            state     <= HDR;
            remaining <= 16'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            blk_ready <= 1'b0;
            pkt_count <= 16'd0;
            err_count <= 16'd0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    if (pipe_in_valid && hdr_ok && (pipe_in_data[15:0] != 16'd0)) begin
                        remaining <= pipe_in_data[15:0];
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // Dropped words still consume length so framing stays aligned.
                    if (pipe_in_valid) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= HDR;
                        end
                        if (full) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: state <= HDR;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            blk_ready <= ((CW'(DEPTH) - count_next) >= CW'(BLOCK_WORDS));

            if (err_evt && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (pkt_evt && (pkt_count != 16'hFFFF)) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_pkt_rx.sv
// tb_pipe_pkt_rx: randomized self-checking bench for pipe_pkt_rx. A queue-based
// reference model tracks framing, FIFO contents and counters; every cycle the
// DUT outputs are compared against it.
module tb_pipe_pkt_rx;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BLOCK  = 4;

    logic        okClk = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] pipe_in_data  = 32'd0;
    logic        pipe_in_valid = 1'b0;
    logic        blk_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        overflow;

    pipe_pkt_rx #(
        .DEPTH_LOG2 (4),
        .BLOCK_WORDS(4),
        .MAGIC      (16'hA5A5)
    ) dut (
        .okClk        (okClk),
        .rstn         (rstn),
        .pipe_in_data (pipe_in_data),
        .pipe_in_valid(pipe_in_valid),
        .blk_ready    (blk_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .pkt_count    (pkt_count),
        .err_count    (err_count),
        .overflow     (overflow)
    );

    always #5 okClk = ~okClk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [32:0] q[$];
    bit          in_pkt;
    int          rem;
    int          exp_pkt;
    int          exp_err;
    bit          exp_ovf;
    bit          exp_blk;
    int          lasts_popped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_pkt  = 1'b0;
        rem     = 0;
        exp_pkt = 0;
        exp_err = 0;
        exp_ovf = 1'b0;
        exp_blk = 1'b0;
    endtask

    // One clock of the reference model, evaluated on the pre-edge state.
    task automatic model_step(input bit v, input logic [31:0] d, input bit r);
        bit          do_pop;
        bit          do_push;
        bit          was_full;
        logic [32:0] ent;
        do_pop   = r && (q.size() > 0);
        was_full = (q.size() == DEPTH);
        do_push  = 1'b0;
        ent      = '0;
        if (v) begin
            if (!in_pkt) begin
                if (d[31:16] == 16'hA5A5 && d[15:0] != 16'd0) begin
                    in_pkt = 1'b1;
                    rem    = int'(d[15:0]);
                end else if (exp_err < 65535) begin
                    exp_err++;
                end
            end else begin
                if (was_full) begin
                    if (exp_err < 65535) exp_err++;
                    exp_ovf = 1'b1;
                end else begin
                    do_push = 1'b1;
                    ent     = {(rem == 1), d};
                    if (rem == 1 && exp_pkt < 65535) exp_pkt++;
                end
                rem--;
                if (rem == 0) in_pkt = 1'b0;
            end
        end
        if (do_pop) begin
            if (q[0][32]) lasts_popped++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(ent);
        exp_blk = ((DEPTH - q.size()) >= BLOCK);
    endtask

    task automatic compare_all();
        logic [32:0] h;
        check("m_valid", 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            check("m_data", m_data, h[31:0]);
            check("m_last", 32'(m_last), 32'(h[32]));
        end
        check("blk_ready", 32'(blk_ready), 32'(exp_blk));
        check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // Drive one cycle of stimulus, advance model and DUT, then compare.
    task automatic cycle(input bit v, input logic [31:0] d, input bit r);
        pipe_in_valid = v;
        pipe_in_data  = d;
        m_ready       = r;
        model_step(v, d, r);
        @(posedge okClk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_blk_ready", 32'(blk_ready), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    // Assert reset between edges, check outputs, release and see blk_ready rise.
    task automatic do_reset();
        pipe_in_valid = 1'b0;
        m_ready       = 1'b0;
        rstn          = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        repeat (2) @(posedge okClk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
    endtask

    task automatic send_pkt(input int len, input bit r);
        cycle(1'b1, {16'hA5A5, 16'(len)}, r);
        for (int i = 0; i < len; i++) cycle(1'b1, $urandom, r);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        model_reset();
        lasts_popped = 0;
        do_reset();

        // Basic packet with m_ready held high
        cycle(1'b1, 32'hA5A5_0003, 1'b1);
        cycle(1'b1, 32'd11, 1'b1);
        check("basic_w0", m_data, 32'd11);
        cycle(1'b1, 32'd22, 1'b1);
        check("basic_w1", m_data, 32'd22);
        cycle(1'b1, 32'd33, 1'b1);
        check("basic_w2", m_data, 32'd33);
        check("basic_last", 32'(m_last), 32'd1);
        check("basic_pkt", 32'(pkt_count), 32'd1);
        drain(2);

        // Bad headers then a valid 1-word packet
        do_reset();
        cycle(1'b1, 32'h1234_0002, 1'b1);
        cycle(1'b1, 32'hA5A5_0000, 1'b1);
        cycle(1'b1, 32'hA5A5_0001, 1'b1);
        cycle(1'b1, 32'd7, 1'b1);
        check("bad_hdr_word", m_data, 32'd7);
        drain(2);
        check("bad_hdr_err", 32'(err_count), 32'd2);
        check("bad_hdr_pkt", 32'(pkt_count), 32'd1);

        // Overflow with consumer stalled
        do_reset();
        cycle(1'b1, 32'hA5A5_0014, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 12) check("ovf_blk_hi", 32'(blk_ready), 32'd1);
            if (i == 13) check("ovf_blk_lo", 32'(blk_ready), 32'd0);
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_err", 32'(err_count), 32'd4);
        check("ovf_pkt", 32'(pkt_count), 32'd0);
        drain(17);
        send_pkt(2, 1'b1);
        drain(3);
        check("ovf_follow_pkt", 32'(pkt_count), 32'd1);

        // Push and pop in the same cycle while full
        do_reset();
        cycle(1'b1, 32'hA5A5_0011, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
        check("full_pop_err", 32'(err_count), 32'd1);
        check("full_pop_cnt", 32'(q.size()), 32'd15);
        drain(17);

        // Backpressure over packets of length 1, 5, 16 with throttled input
        do_reset();
        lasts_popped = 0;
        begin
            int lens[3] = '{1, 5, 16};
            int budget;
            for (int p = 0; p < 3; p++) begin
                for (int w = 0; w <= lens[p]; w++) begin
                    logic [31:0] d;
                    d = (w == 0) ? {16'hA5A5, 16'(lens[p])} : $urandom;
                    budget = 0;
                    while (!exp_blk && budget < 200) begin
                        cycle(1'b0, 32'd0, 1'(($urandom & 1)));
                        budget++;
                    end
                    cycle(1'b1, d, 1'(($urandom & 1)));
                end
            end
            for (int i = 0; i < 60; i++) cycle(1'b0, 32'd0, 1'(($urandom & 1)));
            drain(20);
        end
        check("bp_lasts", 32'(lasts_popped), 32'd3);
        check("bp_empty", 32'(m_valid), 32'd0);

        // Reset in the middle of a packet
        cycle(1'b1, 32'hA5A5_0004, 1'b0);
        cycle(1'b1, 32'd1, 1'b0);
        cycle(1'b1, 32'd2, 1'b0);
        do_reset();
        cycle(1'b1, 32'hA5A5_0001, 1'b1);
        cycle(1'b1, 32'h55, 1'b1);
        check("mid_rst_word", m_data, 32'h55);
        check("mid_rst_last", 32'(m_last), 32'd1);
        drain(2);

        // Random mixed traffic
        for (int n = 0; n < 800; n++) begin
            int k;
            logic [31:0] d;
            k = int'($urandom_range(0, 9));
            if (!in_pkt && k == 0)      d = {16'($urandom), 16'($urandom_range(0, 3))};
            else if (!in_pkt && k < 6)  d = {16'hA5A5, 16'($urandom_range(0, 20))};
            else                        d = $urandom;
            cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
        end
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
